// File: rtl/ifetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl_pkg
//   Shared types and constants for the instruction-fetch front end.
//   - ifetch_state_t : fetch controller states (FETCH, HOLD, DISCARD)
//   - PC_STEP        : sequential PC increment
//   - isAligned()    : true when an address is a legal 4-byte fetch target
// ---------------------------------------------------------------------------
package ifetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } ifetch_state_t;

  localparam logic [63:0] PC_STEP = 64'd4;

  function automatic logic isAligned(input logic [63:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_obuf.sv
// ---------------------------------------------------------------------------
// ifetch_obuf
//   Output register between the fetch controller and the fetch stage.
//   Captures {pc, instruction, exception} on load, holds it while the
//   consumer stalls, and drops it on consume or kill.
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_load           capture i_pc/i_instr/i_exception, raise o_valid
//   i_kill           drop the held entry (redirect), wins over everything
//   i_stall          consumer cannot accept this cycle
//   i_pc/i_instr/i_exception   values to capture
//   o_valid/o_pc/o_instr/o_exception   registered outputs
// ---------------------------------------------------------------------------
module ifetch_obuf (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_kill,
  input  logic        i_stall,
  input  logic [63:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_exception,
  output logic        o_valid,
  output logic [63:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_exception
);

  // Kill beats load and consume. On consume only the valid flag drops; the
  // payload is left in place since it is meaningless without valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_instr     <= '0;
      o_exception <= 1'b0;
    end else if (i_kill) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid     <= 1'b1;
      o_pc        <= i_pc;
      o_instr     <= i_instr;
      o_exception <= i_exception;
    end else if (o_valid && !i_stall) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
//   Instruction-fetch front end. Owns the architectural PC, issues one
//   request at a time on the instruction bus, and hands the returned word
//   (or a misaligned-address fault) to the fetch stage through ifetch_obuf.
//   Redirects may arrive at any time, including mid-request.
// Parameters
//   RESET_PC        PC loaded on reset
// Ports
//   i_clk, i_reset                  clock, synchronous active-high reset
//   o_ireq_valid, o_ireq_addr       ibus request (stable until data_ok)
//   i_iresp_addr_ok                 ibus address accept (informational)
//   i_iresp_data_ok, i_iresp_data   ibus data return
//   i_redirect, i_redirect_pc       flush and refetch from target
//   i_stall                         fetch stage back-pressure
//   o_out_valid, o_out_pc, o_out_raw_instr, o_out_exception   to fetch stage
// ---------------------------------------------------------------------------
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_ireq_valid,
  output logic [63:0] o_ireq_addr,
  input  logic        i_iresp_addr_ok,
  input  logic        i_iresp_data_ok,
  input  logic [31:0] i_iresp_data,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_out_valid,
  output logic [63:0] o_out_pc,
  output logic [31:0] o_out_raw_instr,
  output logic        o_out_exception
);

  ifetch_state_t r_state;
  logic [63:0]   r_pc;
  logic          r_ireqValid;
  logic [63:0]   r_ireqAddr;

  ifetch_state_t w_nextState;
  logic [63:0]   w_nextPc;
  logic          w_nextReqValid;
  logic [63:0]   w_nextReqAddr;
  logic          w_dataOk;
  logic          w_load;
  logic [31:0]   w_loadInstr;
  logic          w_loadExc;
  logic          w_kill;
  logic          w_unused;

  // Address accept carries no information this controller needs.
  assign w_unused = i_iresp_addr_ok;

  // Data only counts against a request we actually have on the bus; this
  // also makes a stray data_ok after reset harmless.
  assign w_dataOk = r_ireqValid & i_iresp_data_ok;

  // Next-state decode. The request register is computed from the next PC so
  // a new request is visible the cycle right after a consume or redirect.
  // Leaving FETCH with a request still in flight goes through DISCARD, which
  // keeps the old address on the bus until its data comes back.
  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextReqValid = r_ireqValid;
    w_nextReqAddr  = r_ireqAddr;
    w_load         = 1'b0;
    w_loadInstr    = '0;
    w_loadExc      = 1'b0;
    w_kill         = 1'b0;
    unique case (r_state)
      FETCH: begin
        if (i_redirect) begin
          w_nextPc = i_redirect_pc;
          if (r_ireqValid && !w_dataOk) begin
            w_nextState = DISCARD;
          end else begin
            w_nextReqValid = isAligned(i_redirect_pc);
            w_nextReqAddr  = i_redirect_pc;
          end
        end else if (!isAligned(r_pc)) begin
          w_load         = 1'b1;
          w_loadExc      = 1'b1;
          w_nextState    = HOLD;
          w_nextReqValid = 1'b0;
        end else if (!r_ireqValid) begin
          // Only reached right after reset: raise the first request.
          w_nextReqValid = 1'b1;
          w_nextReqAddr  = r_pc;
        end else if (w_dataOk) begin
          w_load         = 1'b1;
          w_loadInstr    = i_iresp_data;
          w_nextState    = HOLD;
          w_nextReqValid = 1'b0;
        end
      end
      HOLD: begin
        w_nextReqValid = 1'b0;
        if (i_redirect) begin
          w_kill         = 1'b1;
          w_nextPc       = i_redirect_pc;
          w_nextState    = FETCH;
          w_nextReqValid = isAligned(i_redirect_pc);
          w_nextReqAddr  = i_redirect_pc;
        end else if (!i_stall) begin
          w_nextPc       = r_pc + PC_STEP;
          w_nextState    = FETCH;
          w_nextReqValid = isAligned(r_pc + PC_STEP);
          w_nextReqAddr  = r_pc + PC_STEP;
        end
      end
      DISCARD: begin
        if (i_redirect) begin
          w_nextPc = i_redirect_pc;
        end
        if (w_dataOk) begin
          w_nextState    = FETCH;
          w_nextReqValid = isAligned(w_nextPc);
          w_nextReqAddr  = w_nextPc;
        end
      end
      default: begin
        w_nextState    = FETCH;
        w_nextReqValid = 1'b0;
      end
    endcase
  end

  // Controller state, PC and the registered bus request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_ireqValid <= 1'b0;
      r_ireqAddr  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_ireqValid <= w_nextReqValid;
      r_ireqAddr  <= w_nextReqAddr;
    end
  end

  assign o_ireq_valid = r_ireqValid;
  assign o_ireq_addr  = r_ireqAddr;

  ifetch_obuf u_obuf (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_kill      (w_kill),
    .i_stall     (i_stall),
    .i_pc        (r_pc),
    .i_instr     (w_loadInstr),
    .i_exception (w_loadExc),
    .o_valid     (o_out_valid),
    .o_pc        (o_out_pc),
    .o_instr     (o_out_raw_instr),
    .o_exception (o_out_exception)
  );

endmodule
